// File: rtl/dvbt_pkg.sv
// dvbt_pkg: DVB-T outer-code constants shared by the deinterleaver and RS decoder.
// Branch geometry helpers are evaluated at elaboration only.
package dvbt_pkg;
    localparam int I_DEF = 12;
    localparam int M_DEF = 17;
    localparam int DEINT_DEPTH = 1122;
    localparam int PKT_LEN = 204;
    localparam logic [7:0] SYNC_BYTE = 8'h47;
    localparam logic [7:0] SYNC_BYTE_INV = 8'hB8;

    function automatic int branch_len(input int i, input int m, input int j);
        return (i - 1 - j) * m;
    endfunction

    function automatic int branch_base(input int i, input int m, input int j);
        int b;
        b = 0;
        for (int k = 0; k < j; k++) b += branch_len(i, m, k);
        return b;
    endfunction
endpackage

// File: rtl/deint_ram.sv
// deint_ram: single-port read-first byte RAM holding every branch cell of the deinterleaver.
module deint_ram #(
    parameter int DEPTH = 1122,
    parameter int AW = 11
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge Clk)
        if (we) begin
            rdata <= mem[addr];
            mem[addr] <= wdata;
        end
endmodule

// File: rtl/outer_deinterleaver.sv
// outer_deinterleaver: Forney convolutional deinterleaver (I branches, M-byte cell unit)
// with commutator realignment on in_sync and a priming counter.
module outer_deinterleaver
    import dvbt_pkg::*;
#(
    parameter int I = I_DEF,
    parameter int M = M_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] in,
    input  logic       in_valid,
    input  logic       in_sync,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       out_sync,
    output logic       primed,
    output logic       sync_err
);
    localparam int DEP = branch_base(I, M, I);
    localparam int AW = $clog2(DEP);
    localparam int PW = $clog2((I - 1) * M + 1);
    localparam int BW = $clog2(I);
    localparam int SAT = (I - 1) * M * I;
    localparam int CW = $clog2(SAT + 1);

    logic [AW-1:0] base_tbl [I];
    logic [PW-1:0] len_tbl [I];
    logic [BW-1:0] br_q, br_d, eff;
    logic [PW-1:0] ptr_q [I];
    logic [PW-1:0] ptr_d [I];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d, rdata;
    logic valid_q, valid_d, pass_q, pass_d, osync_q, osync_d, err_q, err_d;
    logic misalign, ram_we;
    logic [AW-1:0] addr;

    for (genvar j = 0; j < I; j++) begin : g_tbl
        assign base_tbl[j] = AW'(branch_base(I, M, j));
        assign len_tbl[j] = PW'(branch_len(I, M, j));
    end

    always_comb begin
        misalign = in_valid && in_sync && br_q != '0;
        eff = misalign ? '0 : br_q;
        br_d = br_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (in_valid) begin
            br_d = (eff == BW'(I - 1)) ? '0 : eff + 1'b1;
            if (eff != BW'(I - 1))
                ptr_d[eff] = (ptr_q[eff] == len_tbl[eff] - 1'b1) ? '0 : ptr_q[eff] + 1'b1;
            cnt_d = misalign ? '0 : (cnt_q == CW'(SAT)) ? cnt_q : cnt_q + 1'b1;
        end
        primed = cnt_q == CW'(SAT);
        valid_d = in_valid;
        pass_d = eff == BW'(I - 1);
        byte_d = in;
        osync_d = in_valid && in_sync && br_q == '0 && primed;
        err_d = misalign;
        addr = base_tbl[eff] + AW'(ptr_q[eff]);
        ram_we = in_valid && !Reset && !pass_d;
    end

    always_ff @(posedge Clk)
        if (Reset) begin
            br_q <= '0;
            ptr_q <= '{default: '0};
            cnt_q <= '0;
            byte_q <= '0;
            valid_q <= 1'b0;
            pass_q <= 1'b0;
            osync_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            br_q <= br_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            byte_q <= byte_d;
            valid_q <= valid_d;
            pass_q <= pass_d;
            osync_q <= osync_d;
            err_q <= err_d;
        end

    deint_ram #(.DEPTH(DEP), .AW(AW)) u_ram (
        .Clk(Clk),
        .we(ram_we),
        .addr(addr),
        .wdata(in),
        .rdata(rdata)
    );

    // The RAM read register is unreset, so gate it to keep out at zero whenever nothing is valid.
    assign out = valid_q ? (pass_q ? byte_q : rdata) : 8'h00;
    assign out_valid = valid_q;
    assign out_sync = osync_q;
    assign sync_err = err_q;
endmodule

// File: tb/tb_outer_deinterleaver.sv
// tb_outer_deinterleaver: scoreboard bench; a golden Forney interleaver feeds the DUT.
module tb_outer_deinterleaver;
    import dvbt_pkg::*;
    localparam int I = I_DEF;
    localparam int M = M_DEF;
    localparam int SAT = (I - 1) * M * I;

    typedef struct {
        bit chk;
        logic [7:0] d;
        bit s;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic [7:0] in_b = 8'h00;
    logic in_valid = 1'b0;
    logic in_sync = 1'b0;
    logic [7:0] out_b;
    logic out_valid, out_sync, primed, sync_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] src [];
    exp_t sb [$];

    outer_deinterleaver #(.I(I), .M(M)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .in(in_b),
        .in_valid(in_valid),
        .in_sync(in_sync),
        .out(out_b),
        .out_valid(out_valid),
        .out_sync(out_sync),
        .primed(primed),
        .sync_err(sync_err)
    );

    always #5 Clk = ~Clk;

    task automatic cyc(input logic v, input logic [7:0] d, input logic s);
        in_valid = v;
        in_b = d;
        in_sync = s;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc(1'b1, 8'hFF, 1'b1);
        Reset = 1'b0;
        in_valid = 1'b0;
        in_sync = 1'b0;
    endtask

    task automatic gen_src(input int npkt);
        src = new[npkt * PKT_LEN];
        for (int k = 0; k < npkt * PKT_LEN; k++)
            src[k] = (k % PKT_LEN == 0) ? SYNC_BYTE : 8'($urandom_range(0, 255));
    endtask

    // Golden interleaver: branch j delays by j*M visits of I bytes each.
    function automatic logic [7:0] ilv(input int t);
        int k;
        k = t - (t % I) * M * I;
        return (k >= 0) ? src[k] : 8'h00;
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        cyc(1'b1, 8'hAA, 1'b1);
        n_cmp++;
        if (out_b !== 8'h00 || out_valid !== 1'b0 || out_sync !== 1'b0 || primed !== 1'b0 || sync_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state out=%h v=%b s=%b p=%b e=%b want all 0", out_b, out_valid, out_sync, primed, sync_err);
        end
        Reset = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || sync_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle out_valid=%b sync_err=%b want 0 0", out_valid, sync_err);
        end
    endtask

    task automatic test_passthrough();
        exp_t e;
        do_reset();
        for (int t = 0; t < 36; t++) begin
            sb.push_back('{t % I == I - 1, 8'hA5, 1'b0});
            cyc(1'b1, (t % I == I - 1) ? 8'hA5 : 8'(t), 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || out_sync !== e.s) begin
                n_err++;
                $display("FAIL pass_valid t=%0d out_valid=%b out_sync=%b want 1 %b", t, out_valid, out_sync, e.s);
            end
            if (e.chk) begin
                n_cmp++;
                if (out_b !== e.d) begin
                    n_err++;
                    $display("FAIL pass_data t=%0d out=%h want %h", t, out_b, e.d);
                end
            end
        end
    endtask

    task automatic test_branch10();
        exp_t e;
        do_reset();
        for (int t = 0; t < 204; t++) cyc(1'b1, 8'h00, 1'b0);
        for (int t = 0; t < 216; t++) begin
            sb.push_back('{t == 202 || t == 214, (t == 214) ? 8'h3C : 8'h00, 1'b0});
            cyc(1'b1, (t == 10) ? 8'h3C : 8'h00, 1'b0);
            e = sb.pop_front();
            if (e.chk) begin
                n_cmp++;
                if (out_b !== e.d || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL br10_delay t=%0d out=%h v=%b want %h 1", t, out_b, out_valid, e.d);
                end
            end
        end
    endtask

    task automatic test_end_to_end(input int pct, input bit rst);
        exp_t e;
        int t;
        t = 0;
        if (rst) do_reset();
        gen_src(30);
        while (t < src.size()) begin
            if (int'($urandom_range(0, 99)) < pct) begin
                cyc(1'b0, 8'h00, 1'b0);
                n_cmp++;
                if (out_valid !== 1'b0 || sync_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL e2e_bubble t=%0d out_valid=%b sync_err=%b want 0 0", t, out_valid, sync_err);
                end
                continue;
            end
            if (t >= SAT) sb.push_back('{1'b1, src[t - SAT], t % PKT_LEN == 0});
            else sb.push_back('{1'b0, 8'h00, 1'b0});
            cyc(1'b1, ilv(t), t % PKT_LEN == 0);
            e = sb.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || sync_err !== 1'b0 || primed !== (t + 1 >= SAT) || out_sync !== e.s) begin
                n_err++;
                $display("FAIL e2e_ctrl t=%0d v=%b e=%b p=%b s=%b want 1 0 %b %b",
                         t, out_valid, sync_err, primed, out_sync, t + 1 >= SAT, e.s);
            end
            if (e.chk) begin
                n_cmp++;
                if (out_b !== e.d) begin
                    n_err++;
                    $display("FAIL e2e_data t=%0d out=%h want %h", t, out_b, e.d);
                end
            end
            t++;
        end
    endtask

    task automatic test_misalign();
        do_reset();
        for (int t = 0; t < 2448; t++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        n_cmp++;
        if (primed !== 1'b1) begin
            n_err++;
            $display("FAIL mis_pre_primed primed=%b want 1", primed);
        end
        for (int t = 0; t < 5; t++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        cyc(1'b1, SYNC_BYTE, 1'b1);
        n_cmp++;
        if (sync_err !== 1'b1 || primed !== 1'b0 || out_sync !== 1'b0) begin
            n_err++;
            $display("FAIL mis_pulse sync_err=%b primed=%b out_sync=%b want 1 0 0", sync_err, primed, out_sync);
        end
        for (int k = 1; k <= SAT; k++) begin
            cyc(1'b1, (k == 11) ? 8'hE7 : 8'($urandom_range(0, 255)), 1'b0);
            if (k == 1) begin
                n_cmp++;
                if (sync_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL mis_one_pulse sync_err=%b want 0", sync_err);
                end
            end
            if (k == 11) begin
                n_cmp++;
                if (out_b !== 8'hE7 || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL mis_br_resume out=%h v=%b want e7 1", out_b, out_valid);
                end
            end
            if (k >= SAT - 1) begin
                n_cmp++;
                if (primed !== (k >= SAT)) begin
                    n_err++;
                    $display("FAIL mis_reprime k=%0d primed=%b want %b", k, primed, k >= SAT);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        gen_src(30);
        for (int t = 0; t < 1000; t++) cyc(1'b1, ilv(t), t % PKT_LEN == 0);
        Reset = 1'b1;
        cyc(1'b1, 8'h55, 1'b1);
        Reset = 1'b0;
        in_valid = 1'b0;
        in_sync = 1'b0;
        n_cmp++;
        if (out_b !== 8'h00 || out_valid !== 1'b0 || out_sync !== 1'b0 || primed !== 1'b0 || sync_err !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset out=%h v=%b s=%b p=%b e=%b want all 0", out_b, out_valid, out_sync, primed, sync_err);
        end
        test_end_to_end(0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_branch10();
        test_end_to_end(0, 1'b1);
        test_end_to_end(30, 1'b1);
        test_misalign();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/outer_deinterleaver.md
OUTER_DEINTERLEAVER -- requirements
Module: outer_deinterleaver

Interface
REQ-001 SHALL have parameter I, default 12: number of commutator branches.
REQ-002 SHALL have parameter M, default 17: cell depth unit in bytes.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in, input, 8 bits: interleaved byte from the inner decoder.
REQ-006 SHALL have port in_valid, input, 1 bit: qualifies in; the block has no backpressure.
REQ-007 SHALL have port in_sync, input, 1 bit: marks the packet-start byte (0x47/0xB8) and is valid only with in_valid.
REQ-008 SHALL have port out, output, 8 bits: deinterleaved byte to RS_Decoder.
REQ-009 SHALL have port out_valid, output, 1 bit: qualifies out.
REQ-010 SHALL have port out_sync, output, 1 bit: first byte of a 204-byte RS packet, asserted only once primed.
REQ-011 SHALL have port primed, output, 1 bit: every branch holds real data.
REQ-012 SHALL have port sync_err, output, 1 bit: one-cycle pulse on commutator misalignment.

Function
REQ-013 SHALL keep commutator index br in 0..I-1; each accepted byte (in_valid=1) uses branch br, then br wraps I-1 -> 0.
REQ-014 SHALL give branch j a FIFO delay of L_j=(I-1-j)*M cells: L_0=187, L_10=17, L_11=0.
REQ-015 SHALL, for branch j with L_j>0, output the oldest cell at RAM[base_j+ptr_j] and write in to the same address (read-before-write).
REQ-016 SHALL wrap ptr_j to 0 after L_j-1; base_j = sum of L_k for k<j; total depth 1122 bytes.
REQ-017 SHALL pass branch I-1 (L=0) straight through.
REQ-018 SHALL register out, out_valid and out_sync, with exactly one cycle of latency from the accepting edge.
REQ-019 SHALL hold br, every ptr_j and RAM contents when in_valid=0, and drive out_valid=0 on the next cycle.
REQ-020 SHALL treat in_sync=1 with br=0 as aligned, with no action taken.
REQ-021 SHALL, on in_sync=1 with br!=0: use branch 0 for that byte, set br to 1 next, pulse sync_err, and clear the prime counter; RAM and ptr_j are not cleared.
REQ-022 SHALL increment an 12-bit prime counter per accepted byte and saturate at (I-1)*M*I=2244; primed=1 at saturation.
REQ-023 SHALL set out_sync to a one-cycle-delayed copy of (in_valid & in_sync & br==0 & primed); the end-to-end delay of 2244=11*204 makes output packet starts coincide with input sync positions.
REQ-024 SHALL, when an in_sync arrives on the same cycle the prime counter would reach saturation, apply the REQ-021 clear first.

Reset
REQ-025 SHALL, on Reset=1 at a rising edge: br=0, all ptr_j=0, prime counter=0, out=0, out_valid=0, out_sync=0, primed=0, sync_err=0.
REQ-026 SHALL not clear RAM contents on Reset; data before priming is don't-care.
REQ-027 SHALL give Reset priority over in_valid on the same edge, so the input byte is dropped.
REQ-028 SHALL fully restart alignment on a mid-stream Reset; the first in_sync after reset re-aligns without pulsing sync_err when br=0.

Structure
REQ-029 SHALL define I, M, depth 1122, packet length 204 and the sync bytes 0x47/0xB8 in shared package dvbt_pkg, used also by RS_Decoder.
REQ-030 SHALL implement the 1122x8 storage as sub-module deint_ram: single-port, synchronous read-first, inferable as block RAM.
REQ-031 SHALL compute branch base offsets as package constants, not at runtime.

Verification
REQ-032 SHALL cover pass-through: reset, stream continuous bytes with br=11 carrying 0xA5 -> out=0xA5 with out_valid=1 one cycle later.
REQ-033 SHALL cover branch 10 delay: value 0x3C accepted at br=10 -> reappears on out exactly 204 accepted bytes later (17 visits).
REQ-034 SHALL cover end-to-end: 30 RS packets through a golden Forney interleaver (I=12, M=17) -> primed rises after byte 2244, out_sync with out=0x47 every 204 bytes, output byte-exact versus the original packets.
REQ-035 SHALL cover gaps: random in_valid=0 bubbles (about 30%) in the REQ-034 stream -> identical output sequence, and out_valid=0 on every bubble+1 cycle.
REQ-036 SHALL cover misalignment: in_sync injected at br=5 -> sync_err one pulse, primed drops, br continues 1,2,..., primed returns after 2244 more bytes.
REQ-037 SHALL cover mid-stream reset: Reset for 1 cycle after 1000 bytes -> all outputs 0 next cycle, then the REQ-034 checks pass on a fresh stream.
